// File: rtl/muldiv_pkg.sv
// muldiv_pkg: FSM states, op encodings and sign helpers shared by the multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    // Sign helpers work in a 128-bit container, so 2*WIDTH may not exceed it.
    localparam int MAXW = 128;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic is_neg(input logic sgn, input logic msb);
        return sgn & msb;
    endfunction

    function automatic logic [MAXW-1:0] cneg(input logic c, input logic [MAXW-1:0] v);
        return c ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (MUL) or restoring shift-subtract (DIV) iteration; DIV path only with MULDIV_DIV_EN.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic             op_i,
`endif
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] part, diff;
`endif

    always_comb begin
        sum = lo_i[0] ? {1'b0, acc_i} + {1'b0, b_i} : {1'b0, acc_i};
        acc_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        part = {acc_i, lo_i[WIDTH-1]};
        diff = part - {1'b0, b_i};
        if (op_i == MD_DIV) begin
            acc_o = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
        end
`endif
    end

endmodule

// File: rtl/risc_muldiv.sv
// risc_muldiv: iterative signed/unsigned multiply/divide unit with core stall; define MULDIV_DIV_EN to include the divider.
module risc_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             stall,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic             dvz
);

    localparam int CW = clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sx_q, sx_d, sy_q, sy_d, dvz_q, dvz_d;
    logic             ok, nx, ny;
    logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d, acc_n, lo_n;
    logic [WIDTH-1:0] z_lo_q, z_lo_d, z_hi_q, z_hi_d;
    logic [W2-1:0]    prod;
`ifdef MULDIV_DIV_EN
    logic             op_q, op_d, zero, fix;
    logic [WIDTH-1:0] quo, rem;
`endif

    assign nx = is_neg(sgn, x[WIDTH-1]);
    assign ny = is_neg(sgn, y[WIDTH-1]);
    assign prod = W2'(cneg(sx_q ^ sy_q, MAXW'({acc_n, lo_n})));

`ifdef MULDIV_DIV_EN
    assign ok = 1'b1;
    assign zero = b_q == '0;
    // Floor rounding: mixed signs with a non-zero remainder step q down and move r to the divisor's side.
    assign fix = !zero && (sx_q ^ sy_q) && acc_n != '0;
    assign quo = zero ? '1 : fix ? ~lo_n : WIDTH'(cneg(sx_q ^ sy_q, MAXW'(lo_n)));
    assign rem = fix ? WIDTH'(cneg(sy_q, MAXW'(b_q - acc_n))) : WIDTH'(cneg(sx_q, MAXW'(acc_n)));
`else
    assign ok = op == MD_MUL;
`endif

    assign stall = run && state_q != DONE && !(state_q == IDLE && !ok);
    assign z_lo = z_lo_q;
    assign z_hi = z_hi_q;
    assign dvz = dvz_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .op_i  (op_q),
`endif
        .acc_i (acc_q),
        .lo_i  (lo_q),
        .b_i   (b_q),
        .acc_o (acc_n),
        .lo_o  (lo_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sx_d = sx_q;
        sy_d = sy_q;
        acc_d = acc_q;
        lo_d = lo_q;
        b_d = b_q;
        z_lo_d = z_lo_q;
        z_hi_d = z_hi_q;
        dvz_d = dvz_q;
`ifdef MULDIV_DIV_EN
        op_d = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (run && ok) begin
                    state_d = BUSY;
                    cnt_d = CW'(WIDTH - 1);
                    sx_d = nx;
                    sy_d = ny;
                    acc_d = '0;
                    lo_d = WIDTH'(cneg(nx, MAXW'(x)));
                    b_d = WIDTH'(cneg(ny, MAXW'(y)));
`ifdef MULDIV_DIV_EN
                    op_d = op;
`endif
                end
            end
            BUSY: begin
                if (!run) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_n;
                    lo_d = lo_n;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        z_lo_d = prod[WIDTH-1:0];
                        z_hi_d = prod[W2-1:WIDTH];
                        dvz_d = 1'b0;
`ifdef MULDIV_DIV_EN
                        if (op_q == MD_DIV) begin
                            z_lo_d = quo;
                            z_hi_d = rem;
                            dvz_d = zero;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            sx_q <= 1'b0;
            sy_q <= 1'b0;
            acc_q <= '0;
            lo_q <= '0;
            b_q <= '0;
            z_lo_q <= '0;
            z_hi_q <= '0;
            dvz_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_q <= MD_MUL;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
            acc_q <= acc_d;
            lo_q <= lo_d;
            b_q <= b_d;
            z_lo_q <= z_lo_d;
            z_hi_q <= z_hi_d;
            dvz_q <= dvz_d;
`ifdef MULDIV_DIV_EN
            op_q <= op_d;
`endif
        end
    end

endmodule
